// File: rtl/sha256_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------
// sha256_pkg: SHA-256 constants, round/schedule helper functions, FSM type
// Revision: 1.0
// -----------------------------------------------------------------------
package sha256_pkg;

  localparam int SHA_DATA_WID = 32;
  localparam int SHA_WORD_NUM = 8;

  // Word 7 (MSBs) is H0/a, word 0 (LSBs) is H7/h.
  localparam logic [255:0] SHA256_IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  localparam logic [31:0] SHA256_K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } sha_state_e;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic [31:0] k_word(input logic [5:0] idx);
    return SHA256_K[idx];
  endfunction

endpackage
`default_nettype wire

// File: rtl/sha256_round.sv
`default_nettype none
// -----------------------------------------------------------------------
// sha256_round: one combinational SHA-256 round on a packed a..h state
// Revision: 1.0
// -----------------------------------------------------------------------
module sha256_round
  import sha256_pkg::*;
(
  input  logic [255:0] iv_state,
  input  logic [31:0]  i_w,
  input  logic [31:0]  i_k,
  output logic [255:0] ov_state
);

  logic [31:0] w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h;
  logic [31:0] w_t1, w_t2;

  always_comb begin
    {w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h} = iv_state;
    w_t1 = w_h + big_sigma1(w_e) + ch(w_e, w_f, w_g) + i_k + i_w;
    w_t2 = big_sigma0(w_a) + maj(w_a, w_b, w_c);
    ov_state = {w_t1 + w_t2, w_a, w_b, w_c, w_d + w_t1, w_e, w_f, w_g};
  end

endmodule
`default_nettype wire

// File: rtl/sha256_compress_iter.sv
`default_nettype none
// -----------------------------------------------------------------------
// sha256_compress_iter: iterative SHA-256 compression, UNROLL rounds/clk
// Revision: 1.0
// -----------------------------------------------------------------------
module sha256_compress_iter
  import sha256_pkg::*;
#(
  parameter int DATA_WID = SHA_DATA_WID,
  parameter int WORD_NUM = SHA_WORD_NUM,
  parameter int UNROLL   = 1,
  parameter int FEED_FWD = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WID*WORD_NUM-1:0] iv_h_data,
  input  logic [DATA_WID*16-1:0]       iv_m_data,
  input  logic                         i_data_vld,
  output logic                         o_rdy,
  output logic [DATA_WID*WORD_NUM-1:0] ov_h_data,
  output logic                         o_h_data_vld
);

  localparam int          ST_WID = DATA_WID * WORD_NUM;
  localparam logic [5:0]  T_STEP = 6'(UNROLL);
  localparam logic [5:0]  LAST_T = 6'(64 - UNROLL);

  if (DATA_WID != 32 || WORD_NUM != 8) begin : g_bad_width
    $error("sha256_compress_iter: only DATA_WID=32, WORD_NUM=8 supported");
  end
  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8)) begin : g_bad_unroll
    $error("sha256_compress_iter: UNROLL must be 1, 2, 4 or 8");
  end

  sha_state_e            state_q, state_d;
  logic [5:0]            t_q, t_d;
  logic [ST_WID-1:0]     work_q, work_d;
  logic [ST_WID-1:0]     ff_q, ff_d;
  logic [15:0][31:0]     w_q, w_d;
  logic [ST_WID-1:0]     h_out_q, h_out_d;
  logic                  vld_q, vld_d;

  logic [31:0]           w_ext [16+UNROLL];
  logic [ST_WID-1:0]     round_out;
  logic [ST_WID-1:0]     ff_sum;

  // Window plus the UNROLL words expanded this cycle; w_ext[u] feeds round t+u.
  always_comb begin
    for (int j = 0; j < 16; j++) begin
      w_ext[j] = w_q[j];
    end
    for (int u = 0; u < UNROLL; u++) begin
      w_ext[16+u] = small_sigma1(w_ext[14+u]) + w_ext[9+u] +
                    small_sigma0(w_ext[1+u]) + w_ext[u];
    end
  end

  for (genvar u = 0; u < UNROLL; u++) begin : g_round
    logic [ST_WID-1:0] st_in;
    logic [ST_WID-1:0] st_out;
    logic [5:0]        k_idx;

    if (u == 0) begin : g_first
      assign st_in = work_q;
    end else begin : g_next
      assign st_in = g_round[u-1].st_out;
    end

    assign k_idx = t_q + 6'(u);

    sha256_round u_round (
      .iv_state (st_in),
      .i_w      (w_ext[u]),
      .i_k      (k_word(k_idx)),
      .ov_state (st_out)
    );
  end

  assign round_out = g_round[UNROLL-1].st_out;

  always_comb begin
    ff_sum = '0;
    for (int i = 0; i < WORD_NUM; i++) begin
      ff_sum[DATA_WID*i +: DATA_WID] = work_q[DATA_WID*i +: DATA_WID] +
                                       ff_q[DATA_WID*i +: DATA_WID];
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    work_d  = work_q;
    ff_d    = ff_q;
    w_d     = w_q;
    h_out_d = h_out_q;
    vld_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_data_vld) begin
          work_d  = iv_h_data;
          ff_d    = iv_h_data;
          w_d     = iv_m_data;
          t_d     = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        work_d = round_out;
        for (int j = 0; j < 16; j++) begin
          w_d[j] = w_ext[j+UNROLL];
        end
        t_d = t_q + T_STEP;
        if (t_q == LAST_T) begin
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        h_out_d = (FEED_FWD != 0) ? ff_sum : work_q;
        vld_d   = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      t_q     <= '0;
      work_q  <= '0;
      ff_q    <= '0;
      w_q     <= '0;
      h_out_q <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      work_q  <= work_d;
      ff_q    <= ff_d;
      w_q     <= w_d;
      h_out_q <= h_out_d;
      vld_q   <= vld_d;
    end
  end

  assign o_rdy        = (state_q == ST_IDLE);
  assign ov_h_data    = h_out_q;
  assign o_h_data_vld = vld_q;

endmodule
`default_nettype wire
